// File: rtl/pattern_seq_pkg.sv
// Shared types and helpers for the pattern bit sequencer.
//   seq_state_t : sequencer FSM states
//   clamp_len   : maps a requested active-bit count onto 1..width
package pattern_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // A length of 0, or one larger than the pattern, selects the full pattern.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/pattern_idx_counter.sv
// Up/down index counter used by the sequencer to walk the pattern.
//   clk, rst   : clock, synchronous active-high reset (index returns to 0)
//   load       : take load_idx as the new index (wins over step)
//   load_idx   : index taken on load
//   step       : advance by one position in the current direction
//   down       : 1 counts down, 0 counts up
//   wrap_idx   : index taken when stepping past end_idx
//   end_idx    : final index of a pass
//   idx        : current index
//   last       : idx equals end_idx
module pattern_idx_counter #(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             step,
    input  logic             down,
    input  logic [IDX_W-1:0] wrap_idx,
    input  logic [IDX_W-1:0] end_idx,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        // NOTE: default assignment first so every path drives idx_d and no latch is inferred.
        idx_d = idx_q;
        if (load) begin
            idx_d = load_idx;
        end else if (step) begin
            // Wrap is explicit at the end index, so the +/-1 never relies on overflow.
            if (last)      idx_d = wrap_idx;
            else if (down) idx_d = idx_q - IDX_W'(1);
            else           idx_d = idx_q + IDX_W'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) idx_q <= '0;
        else     idx_q <= idx_d;
    end

    assign idx  = idx_q;
    assign last = (idx_q == end_idx);

endmodule

// File: rtl/pattern_bit_sequencer.sv
// Pattern register with a registered random-access bit peek and a serial
// bit streamer (LSB- or MSB-first, one-shot or repeating, abortable).
//   clk, rst        : clock, synchronous active-high reset
//   load_*          : pattern/length/direction/repeat load, valid/ready handshake
//   abort           : end streaming, return to IDLE
//   out_valid/ready : streamed-bit handshake; out_bit, out_idx, out_last describe the bit
//   sel_idx/sel_bit : peek index and its registered pattern bit (0 when out of range)
module pattern_bit_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] RESET_PATTERN = 'h2,
    localparam int              IDX_W         = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_pattern,
    input  logic [IDX_W:0]   load_len,
    input  logic             load_msb_first,
    input  logic             load_repeat,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    input  logic [IDX_W-1:0] sel_idx,
    output logic             sel_bit
);

    localparam int LEN_W = IDX_W + 1;

    seq_state_t       state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             msb_q, msb_d;
    logic             rep_q, rep_d;
    logic             sel_bit_q, sel_bit_d;

    logic             load_fire;
    logic             xfer;
    logic [LEN_W-1:0] load_len_c;
    logic [IDX_W-1:0] load_start;
    logic [IDX_W-1:0] wrap_idx;
    logic [IDX_W-1:0] end_idx;
    logic [IDX_W-1:0] idx;
    logic             idx_last;

    assign load_ready = (state_q == IDLE);
    assign out_valid  = (state_q == RUN);
    assign load_fire  = load_valid & load_ready;
    assign xfer       = out_valid & out_ready;

    // Start index is derived from the incoming config on load, from the stored config on wrap.
    assign load_len_c = LEN_W'(clamp_len(32'(load_len), WIDTH));
    assign load_start = load_msb_first ? IDX_W'(load_len_c - LEN_W'(1)) : '0;
    assign wrap_idx   = msb_q ? IDX_W'(len_q - LEN_W'(1)) : '0;
    assign end_idx    = msb_q ? '0 : IDX_W'(len_q - LEN_W'(1));

    pattern_idx_counter #(
        .IDX_W (IDX_W)
    ) u_idx_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (load_fire),
        .load_idx (load_start),
        .step     (xfer),
        .down     (msb_q),
        .wrap_idx (wrap_idx),
        .end_idx  (end_idx),
        .idx      (idx),
        .last     (idx_last)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        msb_d     = msb_q;
        rep_d     = rep_q;

        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    pattern_d = load_pattern;
                    len_d     = load_len_c;
                    msb_d     = load_msb_first;
                    rep_d     = load_repeat;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // A transfer coinciding with abort is still delivered; the counter steps regardless.
                if (abort || (xfer && idx_last && !rep_q)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Peek sees the pattern as it stands now; a same-cycle load shows up on the next sample.
        sel_bit_d = ({1'b0, sel_idx} < LEN_W'(WIDTH)) ? pattern_q[sel_idx] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= RESET_PATTERN;
            len_q     <= LEN_W'(WIDTH);
            msb_q     <= 1'b0;
            rep_q     <= 1'b0;
            sel_bit_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            msb_q     <= msb_d;
            rep_q     <= rep_d;
            sel_bit_q <= sel_bit_d;
        end
    end

    // Stream outputs are qualified by out_valid so they read 0 outside RUN.
    assign out_bit  = out_valid & pattern_q[idx];
    assign out_idx  = idx;
    assign out_last = out_valid & idx_last;
    assign sel_bit  = sel_bit_q;

endmodule

// File: tb/tb_pattern_bit_sequencer.sv
// Directed self-checking bench for pattern_bit_sequencer (WIDTH=8, RESET_PATTERN='h2).
module tb_pattern_bit_sequencer;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_pattern;
    logic [IDX_W:0]   load_len;
    logic             load_msb_first;
    logic             load_repeat;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_bit;

    int checks = 0;
    int errors = 0;

    pattern_bit_sequencer #(
        .WIDTH         (WIDTH),
        .RESET_PATTERN ('h2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .load_valid     (load_valid),
        .load_ready     (load_ready),
        .load_pattern   (load_pattern),
        .load_len       (load_len),
        .load_msb_first (load_msb_first),
        .load_repeat    (load_repeat),
        .abort          (abort),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_bit        (out_bit),
        .out_idx        (out_idx),
        .out_last       (out_last),
        .sel_idx        (sel_idx),
        .sel_bit        (sel_bit)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_stream(input string tag, input logic v, input logic [IDX_W-1:0] i,
                                input logic b, input logic l);
        check({tag, " out_valid"}, 32'(out_valid), 32'(v));
        check({tag, " out_idx"},   32'(out_idx),   32'(i));
        check({tag, " out_bit"},   32'(out_bit),   32'(b));
        check({tag, " out_last"},  32'(out_last),  32'(l));
    endtask

    task automatic do_load(input logic [7:0] pat, input logic [3:0] len,
                           input logic msb, input logic rep);
        load_valid     = 1'b1;
        load_pattern   = pat;
        load_len       = len;
        load_msb_first = msb;
        load_repeat    = rep;
        tick();
        load_valid     = 1'b0;
    endtask

    // Hand-derived bit sequences.
    logic [0:7] a5_lsb = 8'b1010_0101;   // 8'hA5 bits 0..7
    logic [0:2] s06_msb = 3'b110;        // 8'h06 bits 2,1,0

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_pattern = '0; load_len = '0;
        load_msb_first = 1'b0; load_repeat = 1'b0; abort = 1'b0;
        out_ready = 1'b0; sel_idx = '0;
        tick(); tick();
        rst = 1'b0;

        // 1. Reset state and peek of the reset pattern
        check("reset load_ready", 32'(load_ready), 32'd1);
        check_stream("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check("reset sel_bit", 32'(sel_bit), 32'd0);
        sel_idx = 3'd1; tick();
        check("peek rst idx1", 32'(sel_bit), 32'd1);
        sel_idx = 3'd0; tick();
        check("peek rst idx0", 32'(sel_bit), 32'd0);

        // 2. 8'hA5, len 8, LSB-first, one-shot, no backpressure
        out_ready = 1'b1;
        do_load(8'hA5, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_stream("t2", 1'b1, 3'(i), a5_lsb[i], (i == 7));
            check("t2 load_ready", 32'(load_ready), 32'd0);
            tick();
        end
        check("t2 idle valid", 32'(out_valid), 32'd0);
        check("t2 idle ready", 32'(load_ready), 32'd1);
        sel_idx = 3'd6; tick();
        check("t2 peek idx6", 32'(sel_bit), 32'd0);
        sel_idx = 3'd7; tick();
        check("t2 peek idx7", 32'(sel_bit), 32'd1);

        // 3. 8'h06, len 3, MSB-first, one-shot
        do_load(8'h06, 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_stream("t3", 1'b1, 3'(2 - i), s06_msb[i], (i == 2));
            tick();
        end
        check("t3 idle valid", 32'(out_valid), 32'd0);

        // 4. Backpressure for 3 cycles mid-stream
        do_load(8'hA5, 4'd0, 1'b0, 1'b0);   // len 0 selects the full width
        for (int i = 0; i < 3; i++) begin
            check_stream("t4 pre", 1'b1, 3'(i), a5_lsb[i], 1'b0);
            tick();
        end
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_stream("t4 hold", 1'b1, 3'd3, a5_lsb[3], 1'b0);
        end
        out_ready = 1'b1;
        for (int i = 3; i < 8; i++) begin
            check_stream("t4 post", 1'b1, 3'(i), a5_lsb[i], (i == 7));
            tick();
        end
        check("t4 idle valid", 32'(out_valid), 32'd0);

        // 5. Repeat mode, len 2, then abort alongside a transfer
        do_load(8'h02, 4'd2, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check_stream("t5 rep", 1'b1, 3'(i % 2), (i % 2 == 1), (i % 2 == 1));
            tick();
        end
        check_stream("t5 pre-abort", 1'b1, 3'd0, 1'b0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5 abort valid", 32'(out_valid), 32'd0);
        check("t5 abort ready", 32'(load_ready), 32'd1);
        abort = 1'b1; sel_idx = 3'd1;
        tick();
        abort = 1'b0;
        check("t5 idle-abort ready", 32'(load_ready), 32'd1);
        tick();
        check("t5 pattern kept", 32'(sel_bit), 32'd1);

        // 6. load_valid ignored in RUN, then reset mid-run
        do_load(8'hA5, 4'd8, 1'b0, 1'b0);
        tick(); tick();
        check_stream("t6 run", 1'b1, 3'd2, a5_lsb[2], 1'b0);
        load_valid = 1'b1; load_pattern = 8'hFF; load_len = 4'd1;
        tick();
        load_valid = 1'b0;
        check_stream("t6 ignored load", 1'b1, 3'd3, a5_lsb[3], 1'b0);
        check("t6 run ready", 32'(load_ready), 32'd0);
        rst = 1'b1; sel_idx = 3'd0;
        tick();
        rst = 1'b0;
        check_stream("t6 reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check("t6 reset ready", 32'(load_ready), 32'd1);
        check("t6 reset sel_bit", 32'(sel_bit), 32'd0);
        sel_idx = 3'd1;
        tick();
        check("t6 peek idx1", 32'(sel_bit), 32'd1);
        sel_idx = 3'd7;
        tick();
        check("t6 peek idx7", 32'(sel_bit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
